spi_slave: RTL and testbench

- SPI slave front end that turns serial MOSI frames into 10-bit command words for the RAM slave (rx_data/rx_valid).
- Serialises the RAM's 8-bit read response (tx_data/tx_valid) onto MISO.
- Sits between the chip-level SPI pins and the RAM; clk is the SPI serial clock (SCK), and every bit is sampled/driven on posedge clk.

---
 rtl/spi_pkg.sv | 24 ++
 rtl/spi_tx_shifter.sv | 52 +++++
 rtl/spi_slave.sv | 120 ++++++++++++
 tb/tb_spi_slave.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI slave: FSM state encoding, RAM command
// opcodes carried in rx_data[9:8], and default widths.
// No ports; imported by spi_slave and spi_tx_shifter.
package spi_pkg;

  localparam int RX_WIDTH_DEF  = 10;
  localparam int TX_WIDTH_DEF  = 8;
  localparam int CNT_WIDTH_DEF = 4;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CHK_CMD   = 3'd1,
    WRITE     = 3'd2,
    READ_ADD  = 3'd3,
    READ_DATA = 3'd4
  } state_t;

  // Opcodes in the top two bits of a command word; forwarded, never checked.
  localparam logic [1:0] OP_WR_ADDR = 2'b00;
  localparam logic [1:0] OP_WR_DATA = 2'b01;
  localparam logic [1:0] OP_RD_ADDR = 2'b10;
  localparam logic [1:0] OP_RD_DATA = 2'b11;

endpackage

// File: rtl/spi_tx_shifter.sv
// Parallel-load, serial-out MISO register, MSB first.
// Ports: clk/rst_n (sync, active low); clear aborts and zeroes; load captures
//        load_data and drives its MSB; shift_en advances; miso out; done = byte sent.
module spi_tx_shifter
  import spi_pkg::*;
#(
  parameter int TX_WIDTH  = TX_WIDTH_DEF,
  parameter int CNT_WIDTH = CNT_WIDTH_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clear,
  input  logic                load,
  input  logic [TX_WIDTH-1:0] load_data,
  input  logic                shift_en,
  output logic                miso,
  output logic                done
);

  logic [TX_WIDTH-1:0]  sreg;
  logic [CNT_WIDTH-1:0] bits_out;  // bits already presented on miso
  logic                 active;

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      sreg     <= '0;
      bits_out <= '0;
      active   <= 1'b0;
      miso     <= 1'b0;
      done     <= 1'b0;
    end else if (load) begin
      // The MSB goes out on the load edge itself, so the byte occupies the
      // TX_WIDTH cycles directly following the load.
      miso     <= load_data[TX_WIDTH-1];
      sreg     <= {load_data[TX_WIDTH-2:0], 1'b0};
      bits_out <= CNT_WIDTH'(1);
      active   <= 1'b1;
      done     <= 1'b0;
    end else if (shift_en && active) begin
      if (bits_out == CNT_WIDTH'(TX_WIDTH)) begin
        miso   <= 1'b0;
        active <= 1'b0;
        done   <= 1'b1;
      end else begin
        miso     <= sreg[TX_WIDTH-1];
        sreg     <= {sreg[TX_WIDTH-2:0], 1'b0};
        bits_out <= bits_out + CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/spi_slave.sv
// SPI slave front end: MOSI frames -> 10-bit RAM commands, RAM read byte -> MISO.
// Ports: clk = SCK (posedge), rst_n sync active low, ss_n/mosi/miso pins,
//        rx_data/rx_valid command strobe to RAM, tx_data/tx_valid read response.
module spi_slave
  import spi_pkg::*;
#(
  parameter int RX_WIDTH  = RX_WIDTH_DEF,
  parameter int TX_WIDTH  = TX_WIDTH_DEF,
  parameter int CNT_WIDTH = CNT_WIDTH_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ss_n,
  input  logic                mosi,
  output logic                miso,
  output logic [RX_WIDTH-1:0] rx_data,
  output logic                rx_valid,
  input  logic [TX_WIDTH-1:0] tx_data,
  input  logic                tx_valid
);

  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] bit_cnt;
  logic [RX_WIDTH-2:0]  rx_shift;      // first RX_WIDTH-1 payload bits
  logic                 rx_done;       // payload complete; ignore further mosi
  logic                 rd_addr_done;  // a read address was sent, next read is data
  logic                 tx_wait;       // read command issued, waiting for RAM data
  logic                 tx_load;
  logic                 tx_done;
  logic                 in_payload;

  // ---------------- state register ----------------
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // ---------------- next-state logic ----------------
  always_comb begin
    state_d = state_q;
    if (ss_n) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:    state_d = CHK_CMD;
        CHK_CMD: begin
          if (!mosi)             state_d = WRITE;
          else if (rd_addr_done) state_d = READ_DATA;
          else                   state_d = READ_ADD;
        end
        WRITE, READ_ADD, READ_DATA: state_d = state_q;
        default: state_d = IDLE;
      endcase
    end
  end

  assign in_payload = (state_q == WRITE) || (state_q == READ_ADD) ||
                      (state_q == READ_DATA);

  // Only the first tx_valid after this frame's command counts; tx_wait is set
  // on the completion edge, so a level held over from an earlier read cannot
  // load before the new command has been issued.
  assign tx_load = (state_q == READ_DATA) && !ss_n && tx_wait && tx_valid && !tx_done;

  // ---------------- receive datapath ----------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bit_cnt      <= '0;
      rx_shift     <= '0;
      rx_done      <= 1'b0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      rd_addr_done <= 1'b0;
      tx_wait      <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      if (ss_n) begin
        // Aborted or finished frame: rx_data and rd_addr_done keep their values.
        bit_cnt <= '0;
        rx_done <= 1'b0;
        tx_wait <= 1'b0;
      end else if (state_q == CHK_CMD) begin
        bit_cnt <= '0;
        rx_done <= 1'b0;
      end else if (in_payload && !rx_done) begin
        rx_shift <= {rx_shift[RX_WIDTH-3:0], mosi};
        if (bit_cnt == CNT_WIDTH'(RX_WIDTH - 1)) begin
          rx_data  <= {rx_shift, mosi};
          rx_valid <= 1'b1;
          rx_done  <= 1'b1;
          if (state_q == READ_ADD)  rd_addr_done <= 1'b1;
          if (state_q == READ_DATA) begin
            rd_addr_done <= 1'b0;
            tx_wait      <= 1'b1;
          end
        end else begin
          bit_cnt <= bit_cnt + CNT_WIDTH'(1);
        end
      end else if (tx_load) begin
        tx_wait <= 1'b0;
      end
    end
  end

  // ---------------- transmit path ----------------
  spi_tx_shifter #(
    .TX_WIDTH  (TX_WIDTH),
    .CNT_WIDTH (CNT_WIDTH)
  ) u_tx (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (ss_n),
    .load      (tx_load),
    .load_data (tx_data),
    .shift_en  (state_q == READ_DATA),
    .miso      (miso),
    .done      (tx_done)
  );

endmodule

// File: tb/tb_spi_slave.sv
module tb_spi_slave;
  import spi_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n, ss_n, mosi, miso, rx_valid, tx_valid;
  logic [9:0] rx_data;
  logic [7:0] tx_data;

  int checks = 0;
  int errors = 0;

  // Reference model state: what the protocol rules say the slave remembers.
  bit         m_rd_done;
  logic [9:0] m_last;

  // Per-frame observations and expectations. Tick k = sample #1 after the
  // k-th posedge of the frame; bit k of the miso vectors is miso at tick k.
  int          obs_cnt, obs_tick, exp_cnt, exp_tick;
  logic [9:0]  obs_data, exp_data;
  logic [63:0] obs_miso, exp_miso;

  spi_slave dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ss_n     (ss_n),
    .mosi     (mosi),
    .miso     (miso),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data),
    .tx_valid (tx_valid)
  );

  always #5 clk = ~clk;

  task automatic tick(input int k);
    @(posedge clk);
    #1;
    if (rx_valid === 1'b1) begin
      obs_cnt++;
      if (obs_cnt == 1) begin
        obs_tick = k;
        obs_data = rx_data;
      end
    end else if (rx_valid !== 1'b0) begin
      obs_cnt = 99;
    end
    obs_miso[k] = miso;
  endtask

  // Frame: ss_n low for n_low ticks (tick 1 = IDLE sees select, tick 2 = select
  // bit, ticks 3..12 = payload MSB first), then ss_n high for two ticks.
  // tx_valid is a level from tick tx_start on (0 = never); tx_data switches
  // from tx_old to tx_new at tick tx_switch; rst_tick (0 = none) pulses reset.
  task automatic run_frame(input int n_low, input bit sel, input logic [9:0] payload,
                           input int tx_start, input logic [7:0] tx_old,
                           input logic [7:0] tx_new, input int tx_switch,
                           input int rst_tick);
    bit         complete, rd_data_mode;
    int         ld;
    logic [7:0] b;
    // reference model
    complete     = (n_low >= 12);
    rd_data_mode = sel && m_rd_done;
    exp_cnt  = 0;
    exp_tick = 0;
    exp_data = m_last;
    exp_miso = '0;
    if (complete) begin
      exp_cnt  = 1;
      exp_tick = 12;
      exp_data = payload;
      m_last   = payload;
      if (sel) m_rd_done = !m_rd_done;
    end
    if (complete && rd_data_mode && tx_start != 0) begin
      ld = (tx_start > 13) ? tx_start : 13;
      b  = (ld >= tx_switch) ? tx_new : tx_old;
      for (int t = ld; t < ld + 8; t++)
        if (t <= n_low && (rst_tick == 0 || t < rst_tick))
          exp_miso[t] = b[7-(t-ld)];
    end
    if (rst_tick != 0) begin
      m_rd_done = 1'b0;
      m_last    = '0;
    end
    // stimulus
    obs_cnt  = 0;
    obs_tick = 0;
    obs_data = '0;
    obs_miso = '0;
    for (int k = 1; k <= n_low + 2; k++) begin
      ss_n  = (k <= n_low) ? 1'b0 : 1'b1;
      rst_n = (k == rst_tick) ? 1'b0 : 1'b1;
      if (k == 2)                mosi = sel;
      else if (k >= 3 && k <= 12) mosi = payload[12-k];
      else                       mosi = 1'($urandom_range(0, 1));
      tx_valid = (tx_start != 0 && k >= tx_start);
      tx_data  = (k >= tx_switch) ? tx_new : tx_old;
      tick(k);
    end
    tx_valid = 1'b0;
    rst_n    = 1'b1;
  endtask

  function automatic logic [7:0] miso_byte(input logic [63:0] tr, input int first);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[7-i] = tr[first+i];
    return r;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; ss_n = 1'b1; mosi = 1'b0; tx_valid = 1'b0; tx_data = 8'h00;
    for (int i = 0; i < 3; i++) begin @(posedge clk); #1; end
    checks++; if (miso !== 1'b0)     begin errors++; $display("FAIL reset_miso: got %b expected 0", miso); end
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_rx_valid: got %b expected 0", rx_valid); end
    checks++; if (rx_data !== 10'h0) begin errors++; $display("FAIL reset_rx_data: got %h expected 000", rx_data); end
    rst_n = 1'b1;
    m_rd_done = 1'b0;
    m_last    = '0;
    @(posedge clk); #1;
  endtask

  task automatic test_write_addr();
    run_frame(14, 1'b0, 10'h005, 0, 8'h00, 8'h00, 1, 0);
    checks++; if (obs_cnt !== 1)        begin errors++; $display("FAIL wa_pulses: got %0d expected 1", obs_cnt); end
    checks++; if (obs_data !== 10'h005) begin errors++; $display("FAIL wa_data: got %h expected 005", obs_data); end
    checks++; if (obs_tick !== 12)      begin errors++; $display("FAIL wa_latency: got tick %0d expected 12", obs_tick); end
    checks++; if (obs_miso !== 64'h0)   begin errors++; $display("FAIL wa_miso: got %h expected 0", obs_miso); end
  endtask

  task automatic test_write_data();
    // tx_valid held high throughout: a write frame must never drive miso.
    run_frame(16, 1'b0, 10'h1AA, 1, 8'hFF, 8'hFF, 1, 0);
    checks++; if (obs_cnt !== 1)        begin errors++; $display("FAIL wd_pulses: got %0d expected 1", obs_cnt); end
    checks++; if (obs_data !== 10'h1AA) begin errors++; $display("FAIL wd_data: got %h expected 1aa", obs_data); end
    checks++; if (obs_miso !== 64'h0)   begin errors++; $display("FAIL wd_miso: got %h expected 0", obs_miso); end
  endtask

  task automatic test_read_seq();
    // Address frame (rd_addr_done still 0 after writes): no response byte.
    run_frame(20, 1'b1, 10'h205, 13, 8'h55, 8'h55, 1, 0);
    checks++; if (obs_data !== 10'h205) begin errors++; $display("FAIL rd_addr_data: got %h expected 205", obs_data); end
    checks++; if (obs_miso !== 64'h0)   begin errors++; $display("FAIL rd_addr_miso: got %h expected 0", obs_miso); end
    // Data frame: RAM answers one cycle after rx_valid with AA.
    run_frame(24, 1'b1, 10'h300, 13, 8'hAA, 8'hAA, 1, 0);
    checks++; if (obs_data !== 10'h300) begin errors++; $display("FAIL rd_data_cmd: got %h expected 300", obs_data); end
    checks++; if (miso_byte(obs_miso, 13) !== 8'hAA) begin errors++; $display("FAIL rd_data_byte: got %h expected aa", miso_byte(obs_miso, 13)); end
    checks++; if (obs_miso !== exp_miso) begin errors++; $display("FAIL rd_data_trace: got %h expected %h", obs_miso, exp_miso); end
    // rd_addr_done cleared: the next read frame is an address again.
    run_frame(20, 1'b1, 10'h2AB, 13, 8'hFF, 8'hFF, 1, 0);
    checks++; if (obs_miso !== 64'h0)   begin errors++; $display("FAIL rd_again_miso: got %h expected 0", obs_miso); end
  endtask

  task automatic test_abort();
    run_frame(8, 1'b0, 10'h0F0, 0, 8'h00, 8'h00, 1, 0);
    checks++; if (obs_cnt !== 0)        begin errors++; $display("FAIL abort_pulses: got %0d expected 0", obs_cnt); end
    checks++; if (rx_data !== 10'h2AB)  begin errors++; $display("FAIL abort_hold: got %h expected 2ab", rx_data); end
    run_frame(13, 1'b0, 10'h155, 0, 8'h00, 8'h00, 1, 0);
    checks++; if (obs_data !== 10'h155 || obs_cnt !== 1) begin errors++; $display("FAIL abort_next: got %h/%0d expected 155/1", obs_data, obs_cnt); end
  endtask

  task automatic test_reset_mid();
    // rd_addr_done is 1 here, so this frame is READ_DATA; reset lands while C3 shifts.
    run_frame(14, 1'b1, 10'h3C0, 13, 8'hC3, 8'hC3, 1, 14);
    checks++; if (obs_data !== 10'h3C0) begin errors++; $display("FAIL rstmid_cmd: got %h expected 3c0", obs_data); end
    checks++; if (obs_miso !== exp_miso) begin errors++; $display("FAIL rstmid_miso: got %h expected %h", obs_miso, exp_miso); end
    checks++; if (rx_data !== 10'h000)  begin errors++; $display("FAIL rstmid_rx_data: got %h expected 000", rx_data); end
    // Reset cleared rd_addr_done: the next read frame must be READ_ADD.
    run_frame(24, 1'b1, 10'h210, 13, 8'hFF, 8'hFF, 1, 0);
    checks++; if (obs_miso !== 64'h0)   begin errors++; $display("FAIL rstmid_next_is_addr: got %h expected 0", obs_miso); end
  endtask

  task automatic test_stale_tx_valid();
    logic [7:0] old_b, new_b;
    old_b = 8'($urandom);
    new_b = old_b ^ 8'($urandom_range(1, 255));
    run_frame(24, 1'b1, 10'h3A5, 1, old_b, new_b, 13, 0);
    checks++; if (miso_byte(obs_miso, 13) !== new_b) begin errors++; $display("FAIL stale_byte: got %h expected %h", miso_byte(obs_miso, 13), new_b); end
    checks++; if (obs_miso !== exp_miso) begin errors++; $display("FAIL stale_trace: got %h expected %h", obs_miso, exp_miso); end
  endtask

  task automatic test_boundary();
    // ss_n rises right after the 10th bit: word still delivered once.
    run_frame(12, 1'b0, 10'h0C3, 0, 8'h00, 8'h00, 1, 0);
    checks++; if (obs_cnt !== 1 || obs_data !== 10'h0C3) begin errors++; $display("FAIL edge_deliver: got %h/%0d expected 0c3/1", obs_data, obs_cnt); end
    // One bit short: nothing delivered.
    run_frame(11, 1'b0, 10'h1FF, 0, 8'h00, 8'h00, 1, 0);
    checks++; if (obs_cnt !== 0 || rx_data !== 10'h0C3) begin errors++; $display("FAIL edge_short: got %h/%0d expected 0c3/0", rx_data, obs_cnt); end
  endtask

  task automatic test_random();
    bit         sel;
    int         n_low, tx_start, tx_switch;
    logic [1:0] op;
    logic [9:0] payload;
    for (int i = 0; i < 24; i++) begin
      sel       = 1'($urandom_range(0, 1));
      n_low     = $urandom_range(1, 28);
      tx_start  = $urandom_range(0, 22);
      tx_switch = $urandom_range(1, 26);
      if (!sel)          op = $urandom_range(0, 1) ? OP_WR_DATA : OP_WR_ADDR;
      else if (m_rd_done) op = OP_RD_DATA;
      else                op = OP_RD_ADDR;
      payload = {op, 8'($urandom)};
      run_frame(n_low, sel, payload, tx_start, 8'($urandom), 8'($urandom), tx_switch, 0);
      checks++; if (obs_cnt !== exp_cnt) begin errors++; $display("FAIL rnd%0d_pulses: got %0d expected %0d", i, obs_cnt, exp_cnt); end
      checks++; if (obs_tick !== exp_tick || (exp_cnt == 1 && obs_data !== exp_data)) begin
        errors++; $display("FAIL rnd%0d_word: got %h@%0d expected %h@%0d", i, obs_data, obs_tick, exp_data, exp_tick);
      end
      checks++; if (obs_miso !== exp_miso) begin errors++; $display("FAIL rnd%0d_miso: got %h expected %h", i, obs_miso, exp_miso); end
      checks++; if (rx_data !== m_last)    begin errors++; $display("FAIL rnd%0d_hold: got %h expected %h", i, rx_data, m_last); end
    end
  endtask

  initial begin
    test_reset();
    test_write_addr();
    test_write_data();
    test_read_seq();
    test_abort();
    test_reset_mid();
    test_stale_tx_valid();
    test_boundary();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
